simd_regfile_mp: RTL and testbench

- Parametrised, clocked successor to the SIMD unit's 128-bit register file.
- Provides NUM_RD combinational read ports with write-to-read bypass and two lane-masked synchronous write ports: port 0 for ALU writeback, port 1 for the load path.
- Contains a post-reset clear sequencer that zeroes all entries, one per cycle.
- Contains a streaming dump engine that replaces simulation-only file dumps with a synthesizable one-entry-per-cycle readout.

---
 rtl/simd_regfile_mp.sv | 136 +++++++++++++
 tb/tb_simd_regfile_mp.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_regfile_mp.sv
// Lane-masked multi-port SIMD register file with a post-reset clear sequencer
// and a one-entry-per-cycle streaming dump engine.
module simd_regfile_mp #(
    parameter int DATA_W = 128,
    parameter int LANE_W = 16,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 3,
    localparam int NLANE = DATA_W / LANE_W,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     we0,
    input  logic [AW-1:0]            wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic [NLANE-1:0]         wm0,
    input  logic                     we1,
    input  logic [AW-1:0]            wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic [NLANE-1:0]         wm1,
    output logic                     ready,
    input  logic                     dump_req,
    output logic                     dump_valid,
    output logic [AW-1:0]            dump_addr,
    output logic [DATA_W-1:0]        dump_data,
    output logic                     dump_done
);

    typedef enum logic [1:0] {CLEAR, RUN, DUMP} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t             state;
    logic [AW-1:0]      ptr;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [AW-1:0]      ra;
    logic [DATA_W-1:0]  rv;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] base,
                                                     input logic [DATA_W-1:0] wd,
                                                     input logic [NLANE-1:0]  wm);
        logic [DATA_W-1:0] r;
        r = base;
        for (int k = 0; k < NLANE; k++)
            if (wm[k])
                r[k*LANE_W +: LANE_W] = wd[k*LANE_W +: LANE_W];
        return r;
    endfunction

    // Same-address writes are folded into one update so port 0 overrides only its own lanes
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) begin
                mem[ptr] <= '0;
            end else if (we0 && we1 && (wa0 == wa1)) begin
                if (in_range(wa0))
                    mem[wa0] <= lane_merge(lane_merge(mem[wa0], wd1, wm1), wd0, wm0);
            end else begin
                if (we1 && in_range(wa1))
                    mem[wa1] <= lane_merge(mem[wa1], wd1, wm1);
                if (we0 && in_range(wa0))
                    mem[wa0] <= lane_merge(mem[wa0], wd0, wm0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= CLEAR;
            ptr        <= '0;
            ready      <= 1'b0;
            dump_valid <= 1'b0;
            dump_done  <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    ptr <= ptr + AW'(1);
                    if (ptr == LAST) begin
                        state <= RUN;
                        ready <= 1'b1;
                        ptr   <= '0;
                    end
                end
                RUN: begin
                    dump_valid <= 1'b0;
                    dump_done  <= 1'b0;
                    if (dump_req) begin
                        state <= DUMP;
                        ptr   <= '0;
                    end
                end
                DUMP: begin
                    dump_valid <= 1'b1;
                    dump_addr  <= ptr;
                    dump_data  <= mem[ptr];
                    ptr        <= ptr + AW'(1);
                    if (ptr == LAST) begin
                        dump_done <= 1'b1;
                        state     <= RUN;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Read ports see in-flight writes lane by lane, with the same port-0 priority as storage
    always_comb begin
        rd_data = '0;
        ra      = '0;
        rv      = '0;
        if (state != CLEAR) begin
            for (int i = 0; i < NUM_RD; i++) begin
                ra = rd_addr[i*AW +: AW];
                rv = '0;
                if (in_range(ra)) begin
                    rv = mem[ra];
                    if (we1 && (wa1 == ra))
                        rv = lane_merge(rv, wd1, wm1);
                    if (we0 && (wa0 == ra))
                        rv = lane_merge(rv, wd0, wm0);
                end
                rd_data[i*DATA_W +: DATA_W] = rv;
            end
        end
    end

endmodule

// File: tb/tb_simd_regfile_mp.sv
// Scoreboard bench for simd_regfile_mp: an array-based reference model predicts
// reads, ready and dump beats; a negedge monitor pops and compares.
module tb_simd_regfile_mp;

    localparam int DATA_W = 128;
    localparam int LANE_W = 16;
    localparam int DEPTH  = 32;
    localparam int NUM_RD = 3;
    localparam int NLANE  = DATA_W / LANE_W;
    localparam int AW     = 5;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     we0, we1;
    logic [AW-1:0]            wa0, wa1;
    logic [DATA_W-1:0]        wd0, wd1;
    logic [NLANE-1:0]         wm0, wm1;
    logic                     ready;
    logic                     dump_req;
    logic                     dump_valid;
    logic [AW-1:0]            dump_addr;
    logic [DATA_W-1:0]        dump_data;
    logic                     dump_done;

    simd_regfile_mp #(.DATA_W(DATA_W), .LANE_W(LANE_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .we0(we0), .wa0(wa0), .wd0(wd0), .wm0(wm0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .wm1(wm1),
        .ready(ready), .dump_req(dump_req), .dump_valid(dump_valid),
        .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done)
    );

    typedef struct { logic [NUM_RD*DATA_W-1:0] rd; logic rdy; logic dv; } exp_t;
    typedef struct { logic [AW-1:0] addr; logic [DATA_W-1:0] data; logic done; } beat_t;

    exp_t              rq[$];
    beat_t             dq[$];
    logic [DATA_W-1:0] model [DEPTH];
    int                clr_left;
    bit                dmp_active;
    int                dmp_ptr;
    bit                dv_m;
    bit                chk_en;
    int                errors;
    int                checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [DATA_W-1:0] merge(logic [DATA_W-1:0] old, logic [DATA_W-1:0] wd,
                                                logic [NLANE-1:0] wm);
        logic [DATA_W-1:0] r;
        r = old;
        for (int k = 0; k < NLANE; k++)
            if (wm[k]) r[k*LANE_W +: LANE_W] = wd[k*LANE_W +: LANE_W];
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] model_read(int a);
        logic [DATA_W-1:0] v;
        if (clr_left > 0) return '0;
        v = model[a];
        if (we1 && int'(wa1) == a) v = merge(v, wd1, wm1);
        if (we0 && int'(wa0) == a) v = merge(v, wd0, wm0);
        return v;
    endfunction

    // Register file behaviour at one rising edge, from the current inputs
    function automatic void model_edge();
        beat_t b;
        dv_m = 1'b0;
        if (!rst_n) begin
            clr_left   = DEPTH;
            dmp_active = 1'b0;
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else if (clr_left > 0) begin
            clr_left--;
        end else begin
            if (dmp_active) begin
                b.addr = AW'(dmp_ptr);
                b.data = model[dmp_ptr];
                b.done = (dmp_ptr == DEPTH - 1);
                dq.push_back(b);
                dv_m = 1'b1;
                if (dmp_ptr == DEPTH - 1) dmp_active = 1'b0;
                dmp_ptr++;
            end else if (dump_req) begin
                dmp_active = 1'b1;
                dmp_ptr    = 0;
            end
            if (we1) model[wa1] = merge(model[wa1], wd1, wm1);
            if (we0) model[wa0] = merge(model[wa0], wd0, wm0);
        end
    endfunction

    task automatic expect_now();
        exp_t e;
        for (int p = 0; p < NUM_RD; p++)
            e.rd[p*DATA_W +: DATA_W] = model_read(int'(rd_addr[p*AW +: AW]));
        e.rdy = (clr_left == 0);
        e.dv  = dv_m;
        rq.push_back(e);
        chk_en = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk_en = 1'b0;
    endtask

    task automatic cycle();
        expect_now();
        tick();
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; dump_req = 1'b0;
        wm0 = '0; wm1 = '0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic rand_rd();
        for (int p = 0; p < NUM_RD; p++) rd_addr[p*AW +: AW] = rand_addr();
    endtask

    task automatic rand_wr();
        we0 = 1'($urandom_range(0, 1));
        we1 = 1'($urandom_range(0, 1));
        wa0 = rand_addr();
        wa1 = $urandom_range(0, 2) == 0 ? wa0 : rand_addr();
        wd0 = {$urandom, $urandom, $urandom, $urandom};
        wd1 = {$urandom, $urandom, $urandom, $urandom};
        wm0 = NLANE'($urandom_range(0, 255));
        wm1 = NLANE'($urandom_range(0, 255));
    endtask

    task automatic sweep_reads();
        idle();
        for (int s = 0; s < 11; s++) begin
            for (int p = 0; p < NUM_RD; p++) rd_addr[p*AW +: AW] = AW'((s * 3 + p) % DEPTH);
            cycle();
        end
    endtask

    task automatic wait_dump_end(string name);
        int n;
        n = 0;
        idle();
        while (dmp_active && n < 60) begin
            rand_rd();
            cycle();
            n++;
        end
        checks++;
        if (dmp_active) begin
            errors++;
            $display("FAIL %s: dump still active after %0d cycles, required to end", name, n);
        end
    endtask

    always @(negedge clk) begin
        exp_t  e;
        beat_t b;
        if (chk_en) begin
            if (rq.size() == 0) begin
                chk("rq_empty", 1, 0);
            end else begin
                e = rq.pop_front();
                for (int p = 0; p < NUM_RD; p++)
                    chk($sformatf("rd_data[%0d]", p), rd_data[p*DATA_W +: DATA_W], e.rd[p*DATA_W +: DATA_W]);
                chk("ready", 128'(ready), 128'(e.rdy));
                chk("dump_valid", 128'(dump_valid), 128'(e.dv));
            end
            if (dump_valid) begin
                if (dq.size() == 0) begin
                    chk("unexpected_beat", 128'(dump_addr), 128'hDEAD);
                end else begin
                    b = dq.pop_front();
                    chk("dump_addr", 128'(dump_addr), 128'(b.addr));
                    chk("dump_data", dump_data, b.data);
                    chk("dump_done", 128'(dump_done), 128'(b.done));
                end
            end
        end
    end

    initial begin
        exp_t e;
        int   n;
        errors = 0; checks = 0; chk_en = 1'b0;
        clr_left = DEPTH; dmp_active = 1'b0; dmp_ptr = 0; dv_m = 1'b0;
        rst_n = 1'b0; rd_addr = '0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
        idle();
        repeat (3) tick();
        rst_n = 1'b1;

        // Clear phase: ready low for DEPTH cycles, writes and dump_req ignored
        for (int c = 0; c < DEPTH; c++) begin
            rand_wr();
            dump_req = 1'($urandom_range(0, 1));
            rand_rd();
            cycle();
        end
        sweep_reads();

        // Full-width write with same-cycle bypass, then stored readback
        we0 = 1'b1; wa0 = 5; wd0 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF; wm0 = 8'hFF;
        rd_addr = '0; rd_addr[AW-1:0] = 5;
        cycle();
        idle();
        cycle();

        // Dual-port lane priority on one address
        we0 = 1'b1; wa0 = 7; wd0 = '1; wm0 = 8'hFF;
        cycle();
        we0 = 1'b1; wa0 = 7; wd0 = '0; wm0 = 8'h0F;
        we1 = 1'b1; wa1 = 7; wd1 = {8{16'hAAAA}}; wm1 = 8'h3C;
        for (int p = 0; p < NUM_RD; p++) rd_addr[p*AW +: AW] = 7;
        cycle();
        idle();
        for (int p = 0; p < NUM_RD; p++)
            e.rd[p*DATA_W +: DATA_W] = 128'hFFFF_FFFF_AAAA_AAAA_0000_0000_0000_0000;
        e.rdy = 1'b1;
        e.dv  = dv_m;
        rq.push_back(e);
        chk_en = 1'b1;
        tick();

        // Randomized traffic with occasional dumps
        for (int c = 0; c < 400; c++) begin
            rand_wr();
            rand_rd();
            dump_req = ($urandom_range(0, 39) == 0);
            cycle();
        end
        wait_dump_end("random_dump_end");

        // Directed dump: ignored re-request, same-cycle write not reflected
        we0 = 1'b1; wa0 = 3;  wd0 = 128'd3;  wm0 = 8'hFF;
        we1 = 1'b1; wa1 = 31; wd1 = 128'd31; wm1 = 8'hFF;
        cycle();
        idle();
        dump_req = 1'b1;
        cycle();
        n = 0;
        while (dmp_active && n < 60) begin
            idle();
            dump_req = (dmp_ptr == 5);
            if (dmp_ptr == 10) begin
                we0 = 1'b1; wa0 = 10; wd0 = 128'd9; wm0 = 8'hFF;
            end
            rand_rd();
            rd_addr[AW +: AW] = 10;
            cycle();
            n++;
        end
        checks++;
        if (dmp_active) begin
            errors++;
            $display("FAIL directed_dump: still active after %0d cycles, required to end", n);
        end
        idle();
        rd_addr = '0; rd_addr[AW-1:0] = 10;
        cycle();

        // Reset in the middle of a dump after filling registers with garbage
        for (int c = 0; c < DEPTH / 2; c++) begin
            we0 = 1'b1; wa0 = AW'(2 * c);     wd0 = {$urandom, $urandom, $urandom, $urandom}; wm0 = 8'hFF;
            we1 = 1'b1; wa1 = AW'(2 * c + 1); wd1 = {$urandom, $urandom, $urandom, $urandom}; wm1 = 8'hFF;
            dump_req = 1'b0;
            cycle();
        end
        idle();
        dump_req = 1'b1;
        cycle();
        idle();
        n = 0;
        while (!(dmp_active && dmp_ptr == 13) && n < 40) begin
            rand_rd();
            cycle();
            n++;
        end
        checks++;
        if (!(dmp_active && dmp_ptr == 13)) begin
            errors++;
            $display("FAIL reset_dump_wait: beat 12 not reached in %0d cycles", n);
        end
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int c = 0; c < DEPTH; c++) begin
            rand_wr();
            dump_req = 1'($urandom_range(0, 1));
            rand_rd();
            cycle();
        end
        sweep_reads();
        repeat (3) cycle();
        @(negedge clk);
        #1;
        chk("rq_drained", 128'(rq.size()), 128'd0);
        chk("dq_drained", 128'(dq.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
